proj_bottomk_sorter: RTL and testbench
======================================

Name: proj_bottomk_sorter

Overview:
Multi-channel bottom-K sorter for the MinHash datapath. Each cycle it accepts one element carrying NUM_CH hash signatures and one shared index, and maintains, per channel, the K smallest signatures with their indices. Lists are sorted ascending and deduplicated. After the element flagged last, it streams the sketch out through a valid/ready port, then rearms empty for the next document. It sits between the hasher and the extender.

Parameters:
K, 8, list depth per channel (>=2)
NUM_CH, 4, independent hash channels (>=1)
SIG_LEN, 32, signature width
IDX_LEN, 8, index width
DEDUP, 1, 1 = drop a signature already present in that channel's list; 0 = keep duplicates

Ports:
in_clk  input  1  clock
in_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  element valid
in_ready  output  1  sorter can accept an element
in_first  input  1  element starts a new document; lists are treated as empty before inserting it
in_last  input  1  element ends the document; triggers drain
in_signature  input  NUM_CH*SIG_LEN  signature per channel; channel c at [c*SIG_LEN +: SIG_LEN]
in_index  input  IDX_LEN  element index, shared by all channels
out_valid  output  1  drain entry valid
out_ready  input  1  consumer accepts entry
out_channel  output  clog2(NUM_CH) (min 1)  channel of entry
out_rank  output  clog2(K)  rank; 0 = smallest
out_entry_valid  output  1  slot holds a real element
out_signature  output  SIG_LEN  slot signature
out_index  output  IDX_LEN  slot index
out_last  output  1  final entry of sketch

Behaviour:
- Reset (async assert, sync release): all slots invalid (signature '1, index '0). State ACCUM. in_ready=1 once reset is released. out_valid=0, out_last=0. out_channel and out_rank are 0. out_signature='1. out_index=0. out_entry_valid=0.
- Slot emptiness uses a per-slot valid bit, never signature value. An all-ones signature is a legal element.
- ACCUM: in_ready=1. A transfer is in_valid&&in_ready.
- On a transfer, each channel inserts in parallel, 1-cycle latency, so the list updates at the next edge:
  - New signature s goes ahead of the first slot that is invalid or has signature > s.
  - Equal signatures: the existing entry stays ahead, so ordering is stable.
  - Slots at and after the insertion point shift down one. Slot K-1 is discarded.
  - If s >= every valid slot and the list is full, the element is dropped for that channel.
  - DEDUP=1: if s equals any valid slot in that channel, that channel is unchanged.
- in_first on a transfer: insertion is computed against an empty list, so the result is exactly one valid slot per channel.
- in_last on a transfer: the element is inserted, then the state becomes DRAIN at the same edge.
- in_first&&in_last together: a single-element document is drained.
- DRAIN: in_ready=0 and in_valid is ignored.
  - out_valid=1 starting the cycle after the last transfer.
  - Entries are emitted channel-major, rank-ascending: (0,0),(0,1)…(0,K-1),(1,0)…(NUM_CH-1,K-1). That is NUM_CH*K entries, including invalid slots (out_entry_valid=0).
  - The counters advance only on out_valid&&out_ready.
  - All out_* are driven from registers and held stable while out_valid&&!out_ready.
  - out_last=1 only on (NUM_CH-1,K-1).
- Accepting the out_last entry: all slots are cleared, the state becomes ACCUM, and in_ready=1 the next cycle. There is no bubble beyond that one cycle.
- Async reset mid-accumulate or mid-drain: immediate return to reset values. Partial output is abandoned.
- Comparisons are unsigned, full SIG_LEN width.

Decomposition:
- Shared package proj_pkg:
  - typedef bottomk_entry_t {logic valid; logic [SIG_LEN-1:0] signature; logic [IDX_LEN-1:0] index}.
  - Defaults BOTTOMK_K, BOTTOMK_NUM_CH.
  - State enum {ACCUM, DRAIN}.
- Sub-module proj_bottomk_channel: one K-deep insertion list with clear, dedup and a read mux by rank. Instantiated NUM_CH times.
- Top module contents: FSM, drain counters, channel output mux, output registers.

Test Plan:
1. Reset. Pulse in_rst_n low asynchronously mid-cycle, then release. Required: in_ready=1, out_valid=0, and all out_* at their reset values.
2. Basic sort (K=4, NUM_CH=1). Send sigs 50,20,70,10,30 with idx 0..4, last on idx 4. Required drain: idx 3,1,4,0 / sig 10,20,30,50, all out_entry_valid=1, out_last on rank 3, out_valid one cycle after the last transfer.
3. Underfill and in_first. Send sigs 5,9 with in_first on the first and in_last on the second. Required: ranks 0,1 are idx 0,1; ranks 2,3 have out_entry_valid=0. Then a second document with in_first only is not contaminated by the first.
4. Duplicates. Send sig 20 at idx 1 and again at idx 5. DEDUP=1 requires one entry, idx 1. DEDUP=0 requires rank 0 = idx 1, rank 1 = idx 5. Also send sig 'hFFFFFFFF into an empty list; it is stored with valid=1.
5. Backpressure (NUM_CH=2). Hold out_ready=0 for 3 cycles at entry (0,2). Required: out_* stable during the hold, no entry skipped, order (0,0)…(1,3), in_ready=0 throughout the drain, and in_ready=1 the cycle after out_last is accepted.
6. Reset mid-drain (NUM_CH=4). Assert in_rst_n low during entry (2,1). Required: out_valid falls immediately. After release, a new document of 3 elements drains with only those 3 entries valid per channel.

Source files
------------

// File: rtl/proj_pkg.sv
// ----------------------------------------------------------------------------
// proj_pkg
// Shared definitions for the MinHash bottom-K sorter: default sizes, the
// sketch slot record and the sorter FSM state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package proj_pkg;

    localparam int BOTTOMK_K       = 8;
    localparam int BOTTOMK_NUM_CH  = 4;
    localparam int BOTTOMK_SIG_LEN = 32;
    localparam int BOTTOMK_IDX_LEN = 8;

    typedef struct packed {
        logic                       valid;
        logic [BOTTOMK_SIG_LEN-1:0] signature;
        logic [BOTTOMK_IDX_LEN-1:0] index;
    } bottomk_entry_t;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } bottomk_state_t;

endpackage

// File: rtl/proj_bottomk_channel.sv
// ----------------------------------------------------------------------------
// proj_bottomk_channel
// One K-deep ascending insertion list of (signature, index) with per-slot
// valid bits, optional deduplication, synchronous clear and a read port
// selected by rank.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   ins             insert sig/idx this cycle
//   first           compute the insertion against an empty list
//   clear           empty the list at the next edge
//   sig, idx        element to insert
//   rd_next         read the post-edge list instead of the current one
//   rd_rank         slot to read
//   rd_valid/sig/idx  selected slot contents
// ----------------------------------------------------------------------------
module proj_bottomk_channel
    import proj_pkg::*;
#(
    parameter  int K       = BOTTOMK_K,
    parameter  int SIG_LEN = BOTTOMK_SIG_LEN,
    parameter  int IDX_LEN = BOTTOMK_IDX_LEN,
    parameter  int DEDUP   = 1,
    localparam int RW      = $clog2(K)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ins,
    input  logic               first,
    input  logic               clear,
    input  logic [SIG_LEN-1:0] sig,
    input  logic [IDX_LEN-1:0] idx,
    input  logic               rd_next,
    input  logic [RW-1:0]      rd_rank,
    output logic               rd_valid,
    output logic [SIG_LEN-1:0] rd_sig,
    output logic [IDX_LEN-1:0] rd_idx
);

    logic               v_q [K];
    logic [SIG_LEN-1:0] s_q [K];
    logic [IDX_LEN-1:0] x_q [K];
    logic               v_d [K];
    logic [SIG_LEN-1:0] s_d [K];
    logic [IDX_LEN-1:0] x_d [K];
    logic               bv  [K];
    logic [SIG_LEN-1:0] bs  [K];
    logic [IDX_LEN-1:0] bx  [K];
    logic               gt  [K];
    logic               dup;

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < K; i++) begin
            // "base" is the list the insertion is computed against
            bv[i] = v_q[i] && !first;
            bs[i] = first ? '1 : s_q[i];
            bx[i] = first ? '0 : x_q[i];
            // gt is monotonic: valid slots are sorted and invalid ones trail
            gt[i] = !bv[i] || (bs[i] > sig);
            if (bv[i] && (bs[i] == sig)) dup = 1'b1;
        end

        for (int i = 0; i < K; i++) begin
            v_d[i] = v_q[i];
            s_d[i] = s_q[i];
            x_d[i] = x_q[i];
        end

        if (clear) begin
            for (int i = 0; i < K; i++) begin
                v_d[i] = 1'b0;
                s_d[i] = '1;
                x_d[i] = '0;
            end
        end else if (ins && !((DEDUP != 0) && dup)) begin
            if (gt[0]) begin
                v_d[0] = 1'b1;
                s_d[0] = sig;
                x_d[0] = idx;
            end else begin
                v_d[0] = bv[0];
                s_d[0] = bs[0];
                x_d[0] = bx[0];
            end
            for (int i = 1; i < K; i++) begin
                if (!gt[i]) begin
                    v_d[i] = bv[i];
                    s_d[i] = bs[i];
                    x_d[i] = bx[i];
                end else if (!gt[i-1]) begin
                    v_d[i] = 1'b1;
                    s_d[i] = sig;
                    x_d[i] = idx;
                end else begin
                    v_d[i] = bv[i-1];
                    s_d[i] = bs[i-1];
                    x_d[i] = bx[i-1];
                end
            end
        end

        rd_valid = 1'b0;
        rd_sig   = '1;
        rd_idx   = '0;
        for (int i = 0; i < K; i++) begin
            if (RW'(i) == rd_rank) begin
                rd_valid = rd_next ? v_d[i] : v_q[i];
                rd_sig   = rd_next ? s_d[i] : s_q[i];
                rd_idx   = rd_next ? x_d[i] : x_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) begin
                v_q[i] <= 1'b0;
                s_q[i] <= '1;
                x_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            s_q <= s_d;
            x_q <= x_d;
        end
    end

endmodule

// File: rtl/proj_bottomk_sorter.sv
// ----------------------------------------------------------------------------
// proj_bottomk_sorter
// Multi-channel bottom-K sorter: keeps the K smallest signatures per channel
// for one document, then streams the sketch out channel-major, rank-ascending.
// Ports:
//   in_clk, in_rst_n            clock, async active-low reset
//   in_valid/in_ready           element handshake
//   in_first, in_last           document delimiters
//   in_signature, in_index      NUM_CH signatures + shared index
//   out_valid/out_ready         drain handshake
//   out_channel, out_rank       position of the entry
//   out_entry_valid, out_signature, out_index, out_last  entry contents
//
// state | meaning
// ACCUM | accepting elements, lists being built
// DRAIN | streaming NUM_CH*K entries, input stalled
// ----------------------------------------------------------------------------
module proj_bottomk_sorter
    import proj_pkg::*;
#(
    parameter  int K       = BOTTOMK_K,
    parameter  int NUM_CH  = BOTTOMK_NUM_CH,
    parameter  int SIG_LEN = BOTTOMK_SIG_LEN,
    parameter  int IDX_LEN = BOTTOMK_IDX_LEN,
    parameter  int DEDUP   = 1,
    localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int RW      = $clog2(K)
) (
    input  logic                      in_clk,
    input  logic                      in_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [NUM_CH*SIG_LEN-1:0] in_signature,
    input  logic [IDX_LEN-1:0]        in_index,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CW-1:0]             out_channel,
    output logic [RW-1:0]             out_rank,
    output logic                      out_entry_valid,
    output logic [SIG_LEN-1:0]        out_signature,
    output logic [IDX_LEN-1:0]        out_index,
    output logic                      out_last
);

    localparam logic [CW-1:0] CH_MAX = CW'(NUM_CH - 1);
    localparam logic [RW-1:0] RK_MAX = RW'(K - 1);

    bottomk_state_t     state;
    logic               xfer, start, accept;
    logic [CW-1:0]      rd_ch;
    logic [RW-1:0]      rd_rk;
    logic               ch_v [NUM_CH];
    logic [SIG_LEN-1:0] ch_s [NUM_CH];
    logic [IDX_LEN-1:0] ch_x [NUM_CH];
    logic               sel_v;
    logic [SIG_LEN-1:0] sel_s;
    logic [IDX_LEN-1:0] sel_x;

    assign in_ready = (state == ACCUM);
    assign xfer     = in_valid && in_ready;
    assign start    = xfer && in_last;
    assign accept   = (state == DRAIN) && out_valid && out_ready;

    // Address of the entry that goes into the output registers at the next
    // edge: (0,0) when a drain starts, otherwise the successor of the current.
    always_comb begin
        if (state == ACCUM) begin
            rd_ch = '0;
            rd_rk = '0;
        end else if (out_rank == RK_MAX) begin
            rd_ch = out_channel + 1'b1;
            rd_rk = '0;
        end else begin
            rd_ch = out_channel;
            rd_rk = out_rank + 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        proj_bottomk_channel #(
            .K(K), .SIG_LEN(SIG_LEN), .IDX_LEN(IDX_LEN), .DEDUP(DEDUP)
        ) u_ch (
            .clk     (in_clk),
            .rst_n   (in_rst_n),
            .ins     (xfer),
            .first   (in_first),
            .clear   (accept && out_last),
            .sig     (in_signature[c*SIG_LEN +: SIG_LEN]),
            .idx     (in_index),
            // the first entry is taken from the list including the last element
            .rd_next (start),
            .rd_rank (rd_rk),
            .rd_valid(ch_v[c]),
            .rd_sig  (ch_s[c]),
            .rd_idx  (ch_x[c])
        );
    end

    always_comb begin
        sel_v = 1'b0;
        sel_s = '1;
        sel_x = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (CW'(c) == rd_ch) begin
                sel_v = ch_v[c];
                sel_s = ch_s[c];
                sel_x = ch_x[c];
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state           <= ACCUM;
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            out_channel     <= '0;
            out_rank        <= '0;
            out_entry_valid <= 1'b0;
            out_signature   <= '1;
            out_index       <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (start) begin
                        state           <= DRAIN;
                        out_valid       <= 1'b1;
                        out_last        <= 1'b0;
                        out_channel     <= '0;
                        out_rank        <= '0;
                        out_entry_valid <= sel_v;
                        out_signature   <= sel_s;
                        out_index       <= sel_x;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        if (out_last) begin
                            state           <= ACCUM;
                            out_valid       <= 1'b0;
                            out_last        <= 1'b0;
                            out_channel     <= '0;
                            out_rank        <= '0;
                            out_entry_valid <= 1'b0;
                            out_signature   <= '1;
                            out_index       <= '0;
                        end else begin
                            out_channel     <= rd_ch;
                            out_rank        <= rd_rk;
                            out_last        <= (rd_ch == CH_MAX) && (rd_rk == RK_MAX);
                            out_entry_valid <= sel_v;
                            out_signature   <= sel_s;
                            out_index       <= sel_x;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_proj_bottomk_sorter.sv
module tb_proj_bottomk_sorter;
    import proj_pkg::*;

    localparam int K  = 4;
    localparam int NC = 4;
    localparam int SL = 32;
    localparam int IL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, in_valid, in_first, in_last, out_ready;
    logic [NC*SL-1:0] in_sig;
    logic [IL-1:0]  in_idx;

    logic           in_ready_a, out_valid_a, out_ev_a, out_last_a;
    logic [1:0]     out_ch_a, out_rk_a;
    logic [SL-1:0]  out_sig_a;
    logic [IL-1:0]  out_idx_a;
    logic           in_ready_b, out_valid_b, out_ev_b, out_last_b;
    logic [1:0]     out_ch_b, out_rk_b;
    logic [SL-1:0]  out_sig_b;
    logic [IL-1:0]  out_idx_b;

    proj_bottomk_sorter #(.K(K), .NUM_CH(NC), .SIG_LEN(SL), .IDX_LEN(IL), .DEDUP(1)) dut_a (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_first(in_first), .in_last(in_last), .in_signature(in_sig), .in_index(in_idx),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_channel(out_ch_a), .out_rank(out_rk_a),
        .out_entry_valid(out_ev_a), .out_signature(out_sig_a), .out_index(out_idx_a), .out_last(out_last_a));

    proj_bottomk_sorter #(.K(K), .NUM_CH(NC), .SIG_LEN(SL), .IDX_LEN(IL), .DEDUP(0)) dut_b (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_first(in_first), .in_last(in_last), .in_signature(in_sig), .in_index(in_idx),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_channel(out_ch_b), .out_rank(out_rk_b),
        .out_entry_valid(out_ev_b), .out_signature(out_sig_b), .out_index(out_idx_b), .out_last(out_last_b));

    typedef struct {
        logic [1:0]     ch;
        logic [1:0]     rk;
        bottomk_entry_t e;
        logic           last;
    } exp_t;

    typedef struct {
        logic [SL-1:0] sig;
        logic [IL-1:0] idx;
        logic          first;
        logic          last;
        logic [IL-1:0] exp_idx;
        logic [SL-1:0] exp_sig;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    logic [SL-1:0] doc_sig[NC][$];
    logic [IL-1:0] doc_idx[$];

    logic          rec_a_v[NC][K];
    logic [SL-1:0] rec_a_s[NC][K];
    logic [IL-1:0] rec_a_i[NC][K];
    logic          rec_b_v[NC][K];
    logic [IL-1:0] rec_b_i[NC][K];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [1:0] ch, input logic [1:0] rk, input logic ev,
                                       input logic [SL-1:0] s, input logic [IL-1:0] i, input logic last);
        return {18'b0, ch, rk, ev, s, i, last};
    endfunction

    // Reference: stable selection of the K smallest, optionally skipping
    // repeats of an already chosen signature.
    task automatic build_expect();
        bit   used[64];
        int   n, best;
        exp_t x;
        n = doc_idx.size();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NC; c++) begin
                for (int j = 0; j < 64; j++) used[j] = 1'b0;
                for (int r = 0; r < K; r++) begin
                    best = -1;
                    for (int j = 0; j < n; j++)
                        if (!used[j] && (best < 0 || doc_sig[c][j] < doc_sig[c][best])) best = j;
                    x.ch   = 2'(c);
                    x.rk   = 2'(r);
                    x.last = (c == NC-1) && (r == K-1);
                    if (best < 0) begin
                        x.e.valid = 1'b0; x.e.signature = '1; x.e.index = '0;
                    end else begin
                        x.e.valid = 1'b1; x.e.signature = doc_sig[c][best]; x.e.index = doc_idx[best];
                        used[best] = 1'b1;
                        if (d == 0)
                            for (int j = 0; j < n; j++)
                                if (doc_sig[c][j] == doc_sig[c][best]) used[j] = 1'b1;
                    end
                    if (d == 0) q_a.push_back(x);
                    else        q_b.push_back(x);
                end
            end
        end
    endtask

    task automatic send(input logic [NC*SL-1:0] sv, input logic [IL-1:0] idx,
                        input logic f, input logic l);
        int n = 0;
        @(negedge clk);
        while (!in_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 64'(in_ready_a), 64'(1));
        in_sig = sv; in_idx = idx; in_first = f; in_last = l; in_valid = 1'b1;
        @(posedge clk);
        if (f) begin
            for (int c = 0; c < NC; c++) doc_sig[c].delete();
            doc_idx.delete();
        end
        for (int c = 0; c < NC; c++) doc_sig[c].push_back(sv[c*SL +: SL]);
        doc_idx.push_back(idx);
        if (l) build_expect();
        #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain(input int hold_at, input int hold_cycles, input int abort_at);
        int   got = 0, cyc = 0, held = 0;
        exp_t ea, eb;
        while (got < NC*K && cyc < 400) begin
            @(negedge clk);
            cyc++;
            out_ready = !(got == hold_at && held < hold_cycles);
            if (cyc == 1) check("out_valid_latency", 64'(out_valid_a), 64'(1));
            check("in_ready_drain", 64'(in_ready_a), 64'(0));
            if (got == abort_at) begin
                #1 rst_n = 1'b0;
                #1 check("abort_out_valid", 64'(out_valid_a), 64'(0));
                check("abort_out_last", 64'(out_last_a), 64'(0));
                q_a.delete(); q_b.delete();
                out_ready = 1'b1;
                return;
            end
            if (out_valid_a && q_a.size() > 0 && q_b.size() > 0) begin
                ea = q_a[0];
                eb = q_b[0];
                check("entry_dedup1", pk(out_ch_a, out_rk_a, out_ev_a, out_sig_a, out_idx_a, out_last_a),
                      pk(ea.ch, ea.rk, ea.e.valid, ea.e.signature, ea.e.index, ea.last));
                check("entry_dedup0", pk(out_ch_b, out_rk_b, out_ev_b, out_sig_b, out_idx_b, out_last_b),
                      pk(eb.ch, eb.rk, eb.e.valid, eb.e.signature, eb.e.index, eb.last));
                if (out_ready) begin
                    rec_a_v[ea.ch][ea.rk] = out_ev_a;
                    rec_a_s[ea.ch][ea.rk] = out_sig_a;
                    rec_a_i[ea.ch][ea.rk] = out_idx_a;
                    rec_b_v[eb.ch][eb.rk] = out_ev_b;
                    rec_b_i[eb.ch][eb.rk] = out_idx_b;
                    void'(q_a.pop_front());
                    void'(q_b.pop_front());
                    got++;
                end else begin
                    held++;
                end
            end else begin
                check("out_valid_drain", 64'(out_valid_a), 64'(1));
            end
        end
        if (got < NC*K) check("drain_timeout", 64'(got), 64'(NC*K));
        out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_after_dedup1", 64'(in_ready_a), 64'(1));
        check("in_ready_after_dedup0", 64'(in_ready_b), 64'(1));
        check("out_valid_after", 64'(out_valid_a | out_valid_b), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid_a), 64'(0));
        check({tag, "_out_fields"}, pk(out_ch_a, out_rk_a, out_ev_a, out_sig_a, out_idx_a, out_last_a),
              pk(2'd0, 2'd0, 1'b0, '1, '0, 1'b0));
    endtask

    vec_t tv[5];
    logic [SL-1:0] r0, r1, r2, r3;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_sig = '0; in_idx = '0; out_ready = 1'b1;

        // 1. asynchronous reset pulse mid-cycle
        #12 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready_a), 64'(1));
        check_reset_outputs("reset_released");

        // 2. basic sort, channel 0 from the table
        tv[0] = '{32'd50, 8'd0, 1'b1, 1'b0, 8'd3, 32'd10};
        tv[1] = '{32'd20, 8'd1, 1'b0, 1'b0, 8'd1, 32'd20};
        tv[2] = '{32'd70, 8'd2, 1'b0, 1'b0, 8'd4, 32'd30};
        tv[3] = '{32'd10, 8'd3, 1'b0, 1'b0, 8'd0, 32'd50};
        tv[4] = '{32'd30, 8'd4, 1'b0, 1'b1, 8'd0, 32'd0};
        for (int i = 0; i < 5; i++)
            send({32'hFFFF_FFF0 + 32'(i), tv[i].sig * 3, 32'd1000 - tv[i].sig, tv[i].sig},
                 tv[i].idx, tv[i].first, tv[i].last);
        drain(-1, 0, -1);
        for (int r = 0; r < K; r++) begin
            check("basic_idx", 64'(rec_a_i[0][r]), 64'(tv[r].exp_idx));
            check("basic_sig", 64'(rec_a_s[0][r]), 64'(tv[r].exp_sig));
            check("basic_valid", 64'(rec_a_v[0][r]), 64'(1));
        end

        // 3. underfill, then a second document must not see the first
        send({32'd8, 32'd7, 32'd6, 32'd5}, 8'd0, 1'b1, 1'b0);
        send({32'd12, 32'd11, 32'd10, 32'd9}, 8'd1, 1'b0, 1'b1);
        drain(-1, 0, -1);
        check("underfill_r0", 64'(rec_a_i[0][0]), 64'(0));
        check("underfill_r1", 64'(rec_a_i[0][1]), 64'(1));
        check("underfill_r2_invalid", 64'(rec_a_v[0][2]), 64'(0));
        check("underfill_r3_invalid", 64'(rec_a_v[0][3]), 64'(0));
        send({32'd103, 32'd102, 32'd101, 32'd100}, 8'd7, 1'b1, 1'b0);
        send({32'd43, 32'd42, 32'd41, 32'd40}, 8'd8, 1'b0, 1'b1);
        drain(-1, 0, -1);
        check("first_r0", 64'(rec_a_i[0][0]), 64'(8));
        check("first_r1", 64'(rec_a_i[0][1]), 64'(7));
        check("first_r2_invalid", 64'(rec_a_v[0][2]), 64'(0));

        // 4. duplicates and an all-ones signature
        send({32'd7, 32'd20, 32'hFFFF_FFFF, 32'd20}, 8'd1, 1'b1, 1'b0);
        send({32'd7, 32'd30, 32'hFFFF_FFFF, 32'd20}, 8'd5, 1'b0, 1'b1);
        drain(-1, 0, -1);
        check("dedup1_r0", 64'(rec_a_i[0][0]), 64'(1));
        check("dedup1_r1_invalid", 64'(rec_a_v[0][1]), 64'(0));
        check("dedup0_r0", 64'(rec_b_i[0][0]), 64'(1));
        check("dedup0_r1", 64'(rec_b_i[0][1]), 64'(5));
        check("dedup0_r1_valid", 64'(rec_b_v[0][1]), 64'(1));
        check("ones_valid", 64'(rec_a_v[1][0]), 64'(1));
        check("ones_sig", 64'(rec_a_s[1][0]), 64'(32'hFFFF_FFFF));

        // 5. backpressure on entry (0,2), small alphabet to provoke repeats
        for (int i = 0; i < 6; i++) begin
            r0 = $urandom_range(0, 15); r1 = $urandom_range(0, 15);
            r2 = $urandom_range(0, 15); r3 = $urandom_range(0, 15);
            send({r3, r2, r1, r0}, 8'(i + 16), i == 0, i == 5);
        end
        drain(2, 3, -1);

        // 6. reset during entry (2,1), then a fresh 3-element document
        for (int i = 0; i < 5; i++) begin
            r0 = $urandom_range(0, 1000); r1 = $urandom_range(0, 1000);
            r2 = $urandom_range(0, 1000); r3 = $urandom_range(0, 1000);
            send({r3, r2, r1, r0}, 8'(i + 32), i == 0, i == 4);
        end
        drain(-1, 0, 2*K + 1);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_drain_reset");
        for (int i = 0; i < 3; i++)
            send({32'(303 - 10*i), 32'(302 - 10*i), 32'(301 - 10*i), 32'(300 - 10*i)},
                 8'(i + 64), i == 0, i == 2);
        drain(-1, 0, -1);
        for (int c = 0; c < NC; c++) begin
            check("post_reset_r2_valid", 64'(rec_a_v[c][2]), 64'(1));
            check("post_reset_r3_invalid", 64'(rec_a_v[c][3]), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
